// File: rtl/data_memory_unit.sv
// +--------------------------------------------------------------------------+
// | Module      : data_memory_unit                                           |
// | Description : RV32 MEM-stage data memory. Word-addressed RAM with        |
// |               synchronous full-word write, combinational read, per-word  |
// |               valid bits cleared by reset, and a load-size/extension     |
// |               selector driven by the load funct3 code.                   |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
`default_nettype none

module data_memory_unit #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32   // only 32 is supported
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] data,
  input  logic              write,
  input  logic [2:0]        sel,
  output logic [DATA_W-1:0] dmem_out,
  output logic [DATA_W-1:0] out
);

  localparam int DEPTH = 2 ** ADDR_W;

  // Load funct3 encodings
  localparam logic [2:0] C_SEL_LB  = 3'b000;
  localparam logic [2:0] C_SEL_LH  = 3'b001;
  localparam logic [2:0] C_SEL_LW  = 3'b010;
  localparam logic [2:0] C_SEL_LBU = 3'b100;
  localparam logic [2:0] C_SEL_LHU = 3'b101;

  // Data array carries no reset; the valid bits alone decide whether a word
  // is visible, so unwritten or stale contents never reach the outputs.
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DEPTH-1:0]  valid_q;
  logic [DEPTH-1:0]  valid_d;
  logic [DATA_W-1:0] w_word;
  logic [DATA_W-1:0] w_load;

  // Next-state of the valid bits: a store marks its word as valid
  always_comb begin
    valid_d = valid_q;
    if (write) begin
      valid_d[addr] = 1'b1;
    end
  end

  // Valid bits clear asynchronously so every word reads as zero after reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
    end else begin
      valid_q <= valid_d;
    end
  end

  // RAM array write port; stores are blocked while reset is held
  always_ff @(posedge clk) begin
    if (rst_n && write) begin
      mem_q[addr] <= data;
    end
  end

  // Combinational read; no write-first bypass, so a same-cycle store shows
  // up only after the clock edge
  always_comb begin
    w_word = '0;
    if (rst_n && valid_q[addr]) begin
      w_word = mem_q[addr];
    end
  end

  // Narrow and extend the raw word; sub-word loads always use the low lanes
  always_comb begin
    w_load = '0;
    case (sel)
      C_SEL_LB:  w_load = {{24{w_word[7]}},  w_word[7:0]};
      C_SEL_LH:  w_load = {{16{w_word[15]}}, w_word[15:0]};
      C_SEL_LW:  w_load = w_word;
      C_SEL_LBU: w_load = {24'h0, w_word[7:0]};
      C_SEL_LHU: w_load = {16'h0, w_word[15:0]};
      default:   w_load = '0;
    endcase
  end

  assign dmem_out = w_word;
  assign out      = w_load;

endmodule

`default_nettype wire

// File: tb/tb_data_memory_unit.sv
// +--------------------------------------------------------------------------+
// | Module      : tb_data_memory_unit                                        |
// | Description : Self-checking bench for data_memory_unit: directed vectors |
// |               with literal expectations plus a per-cycle comparison      |
// |               against a behavioural memory/load model.                   |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_data_memory_unit;

  localparam int ADDR_W = 12;
  localparam int DEPTH  = 2 ** ADDR_W;

  logic              clk;
  logic              rst_n;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       data;
  logic              write;
  logic [2:0]        sel;
  logic [31:0]       dmem_out;
  logic [31:0]       out;

  int n_checks;
  int n_errors;

  // Behavioural model: plain word array plus written flags
  logic [31:0] m_mem [DEPTH];
  bit          m_val [DEPTH];

  data_memory_unit #(.ADDR_W(ADDR_W), .DATA_W(32)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .addr     (addr),
    .data     (data),
    .write    (write),
    .sel      (sel),
    .dmem_out (dmem_out),
    .out      (out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model update: a store lands on the rising edge when out of reset
  always @(posedge clk) begin
    if (rst_n === 1'b1 && write === 1'b1) begin
      m_mem[addr] = data;
      m_val[addr] = 1'b1;
    end
  end

  // Model reset: forget every stored word
  always @(negedge rst_n) begin
    for (int i = 0; i < DEPTH; i++) m_val[i] = 1'b0;
  end

  function automatic logic [31:0] model_word(input logic [ADDR_W-1:0] a);
    if (rst_n !== 1'b1 || !m_val[a]) return 32'h0;
    return m_mem[a];
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] s, input logic [31:0] w);
    logic signed [7:0]  b;
    logic signed [15:0] h;
    int                 v;
    b = w[7:0];
    h = w[15:0];
    case (s)
      3'd0:    begin v = b; return v; end
      3'd1:    begin v = h; return v; end
      3'd2:    return w;
      3'd4:    return w % 32'd256;
      3'd5:    return w % 32'd65536;
      default: return 32'h0;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    logic [31:0] w;
    w = model_word(addr);
    check("model_dmem_out", dmem_out, w);
    check("model_out", out, model_load(sel, w));
  end

  // Apply inputs a little after the falling edge
  task automatic drive(input logic [ADDR_W-1:0] a, input logic [31:0] d,
                       input logic w, input logic [2:0] s);
    @(negedge clk);
    #2;
    addr  = a;
    data  = d;
    write = w;
    sel   = s;
  endtask

  // One-edge store: write high across exactly one rising edge
  task automatic store(input logic [ADDR_W-1:0] a, input logic [31:0] d);
    drive(a, d, 1'b1, 3'b010);
    @(posedge clk);
    #1;
    write = 1'b0;
  endtask

  task automatic load_check(input string name, input logic [ADDR_W-1:0] a,
                            input logic [2:0] s, input logic [31:0] exp);
    #1;
    addr = a;
    sel  = s;
    #1;
    check(name, out, exp);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst_n = 1'b0;
    addr  = '0;
    data  = '0;
    write = 1'b0;
    sel   = 3'b010;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("reset_dmem_out", dmem_out, 32'h0);
    check("reset_out", out, 32'h0);
    drive(12'd0, 32'h0, 1'b0, 3'b010);
    rst_n = 1'b1;
    begin
      logic [ADDR_W-1:0] ra [4];
      ra = '{12'd0, 12'd2, 12'd7, 12'd4095};
      for (int i = 0; i < 4; i++) begin
        load_check("reset_read_out", ra[i], 3'b010, 32'h0);
        check("reset_read_dmem", dmem_out, 32'h0);
      end
    end

    // Basic store/load, including read-before-edge
    drive(12'd2, 32'd640, 1'b0, 3'b010);
    #1;
    check("pre_write_dmem", dmem_out, 32'h0);
    write = 1'b1;
    #1;
    check("rdw_old_word", dmem_out, 32'h0);
    @(posedge clk);
    #1;
    write = 1'b0;
    check("store_dmem", dmem_out, 32'd640);
    check("store_lw", out, 32'd640);

    // Negative word
    store(12'd7, 32'hFFFFFB00);
    load_check("neg_lb",  12'd7, 3'b000, 32'h00000000);
    load_check("neg_lh",  12'd7, 3'b001, 32'hFFFFFB00);
    load_check("neg_lw",  12'd7, 3'b010, 32'hFFFFFB00);
    load_check("neg_lbu", 12'd7, 3'b100, 32'h00000000);
    load_check("neg_lhu", 12'd7, 3'b101, 32'h0000FB00);

    // Sign extension
    store(12'd5, 32'h000080F0);
    load_check("sx_lb",  12'd5, 3'b000, 32'hFFFFFFF0);
    load_check("sx_lbu", 12'd5, 3'b100, 32'h000000F0);
    load_check("sx_lh",  12'd5, 3'b001, 32'hFFFF80F0);
    load_check("sx_lhu", 12'd5, 3'b101, 32'h000080F0);

    // Top address and reserved encodings
    store(12'd4095, 32'h12345678);
    load_check("top_lw", 12'd4095, 3'b010, 32'h12345678);
    load_check("rsv_011", 12'd4095, 3'b011, 32'h0);
    load_check("rsv_110", 12'd4095, 3'b110, 32'h0);
    load_check("rsv_111", 12'd4095, 3'b111, 32'h0);
    load_check("addr0_unwritten", 12'd0, 3'b010, 32'h0);

    // Write gating: write low across several edges leaves the word alone
    drive(12'd2, 32'd123, 1'b0, 3'b010);
    repeat (3) @(posedge clk);
    #1;
    check("gated_dmem", dmem_out, 32'd640);
    load_check("gated_rsv", 12'd2, 3'b011, 32'h0);

    // Reset mid-operation, between edges
    drive(12'd7, 32'h0, 1'b0, 3'b010);
    #1;
    check("pre_midreset", out, 32'hFFFFFB00);
    rst_n = 1'b0;
    #1;
    check("midreset_dmem", dmem_out, 32'h0);
    check("midreset_out", out, 32'h0);
    data  = 32'd55;
    write = 1'b1;
    @(posedge clk);
    #1;
    write = 1'b0;
    check("reset_write_dmem", dmem_out, 32'h0);
    drive(12'd7, 32'h0, 1'b0, 3'b010);
    rst_n = 1'b1;
    #1;
    check("post_reset_addr7", dmem_out, 32'h0);
    check("post_reset_addr7_out", out, 32'h0);
    load_check("post_reset_addr2", 12'd2, 3'b010, 32'h0);

    // Store after reset works again
    store(12'd7, 32'hA5A5_0081);
    load_check("post_store_lb", 12'd7, 3'b000, 32'hFFFFFF81);
    load_check("post_store_lhu", 12'd7, 3'b101, 32'h00000081);

    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
